// File: rtl/spi_receiver.sv
// spi_receiver: oversampled SPI slave that deserialises MSB-first frames into N-bit words
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   spi_csn           frame select (active low)
//   spi_clk           SPI clock (idle low, data taken on rising edge)
//   spi_mosi          serial data, MSB first
//   rx_data/rx_valid  last accepted word and its valid flag
//   rx_ready          consumer handshake
//   frame_err         one-clk pulse: frame ended with a bit count other than 0 or N
//   overrun           one-clk pulse: completed word dropped because rx_data was still full
module spi_receiver #(
    parameter int N = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         spi_csn,
    input  logic         spi_clk,
    input  logic         spi_mosi,
    output logic [N-1:0] rx_data,
    output logic         rx_valid,
    input  logic         rx_ready,
    output logic         frame_err,
    output logic         overrun
);
    localparam int CW = $clog2(N + 2);
    typedef enum logic {IDLE, RECEIVE} state_t;
    state_t state;
    logic [SYNC_STAGES-1:0] csn_sync, clk_sync, mosi_sync, fill;
    logic csn_d, clk_d, armed;
    logic csn_s, clk_s, mosi_s, csn_fall, csn_rise, clk_rise, frame_end, word_done;
    logic [CW-1:0] cnt, cnt_n;
    logic [N-1:0] shift, shift_n;
    // fill tracks how far real pin samples have propagated since reset, so the
    // preset csn=1 in the chain cannot arm the receiver on its own
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csn_sync  <= '1;
            clk_sync  <= '0;
            mosi_sync <= '0;
            fill      <= '0;
            csn_d     <= 1'b1;
            clk_d     <= 1'b0;
        end else begin
            csn_sync  <= {csn_sync[SYNC_STAGES-2:0], spi_csn};
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], spi_clk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            fill      <= {fill[SYNC_STAGES-2:0], 1'b1};
            csn_d     <= csn_s;
            clk_d     <= clk_s;
        end
    end
    assign csn_s    = csn_sync[SYNC_STAGES-1];
    assign clk_s    = clk_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign csn_fall = csn_d & ~csn_s;
    assign csn_rise = ~csn_d & csn_s;
    assign clk_rise = ~clk_d & clk_s;
    // a bit arriving together with the end of frame is counted before the frame is judged
    always_comb begin
        cnt_n     = (clk_rise && cnt != CW'(N + 1)) ? cnt + CW'(1) : cnt;
        shift_n   = clk_rise ? {shift[N-2:0], mosi_s} : shift;
        frame_end = (state == RECEIVE) && csn_rise;
        word_done = frame_end && cnt_n == CW'(N);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            armed     <= 1'b0;
            cnt       <= '0;
            shift     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= frame_end && cnt_n != '0 && cnt_n != CW'(N);
            overrun   <= word_done && rx_valid && !rx_ready;
            if (csn_s && fill[SYNC_STAGES-1])
                armed <= 1'b1;
            if (word_done && (!rx_valid || rx_ready)) begin
                rx_data  <= shift_n;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            if (state == IDLE) begin
                if (armed && csn_fall) begin
                    cnt   <= '0;
                    shift <= '0;
                    state <= RECEIVE;
                end
            end else begin
                cnt   <= cnt_n;
                shift <= shift_n;
                state <= csn_rise ? IDLE : RECEIVE;
            end
        end
    end
endmodule

// File: tb/tb_spi_receiver.sv
// tb_spi_receiver: randomized and directed frames checked against a pin-level reference model
module tb_spi_receiver;
    localparam int N = 8;
    logic clk, rst, spi_csn, spi_clk, spi_mosi, rx_ready;
    logic [N-1:0] rx_data;
    logic rx_valid, frame_err, overrun;
    int n_cmp = 0, n_bad = 0, err_cnt = 0, ovr_cnt = 0, vrise = 0;
    bit prev_v = 0, rnd_ready = 0;

    spi_receiver #(.N(N), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .spi_csn(spi_csn), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .frame_err(frame_err), .overrun(overrun)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Reference model: watches the pins, collects the bits of each armed frame in a
    // queue, and judges the frame two clocks after csn is first seen high
    logic [N-1:0] exp_data, pend_word;
    logic exp_valid, exp_err, exp_ovr, dlv;
    bit in_frame, armed, prev_csn, prev_sclk;
    int pend_t, pend_len;
    bit q[$];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_data = '0; exp_valid = 0; exp_err = 0; exp_ovr = 0;
            in_frame = 0; armed = 0; prev_csn = 1; prev_sclk = 0;
            pend_t = 0; pend_len = 0; pend_word = '0;
            q.delete();
        end else begin
            exp_err = 0; exp_ovr = 0; dlv = 0;
            if (pend_t > 0) begin
                pend_t--;
                if (pend_t == 0) begin
                    if (pend_len == N) dlv = 1;
                    else if (pend_len != 0) exp_err = 1;
                end
            end
            if (dlv) begin
                if (!exp_valid || rx_ready) begin
                    exp_data = pend_word;
                    exp_valid = 1;
                end else exp_ovr = 1;
            end else if (exp_valid && rx_ready) exp_valid = 0;
            if (in_frame && spi_clk && !prev_sclk) q.push_back(spi_mosi);
            if (in_frame && spi_csn) begin
                in_frame = 0;
                pend_len = q.size();
                if (pend_len == N)
                    for (int i = 0; i < N; i++) pend_word[N-1-i] = q[i];
                pend_t = 2;
            end
            if (armed && prev_csn && !spi_csn) begin
                in_frame = 1;
                q.delete();
            end
            if (spi_csn) armed = 1;
            prev_csn = spi_csn;
            prev_sclk = spi_clk;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            if (!rst) begin
                chk("valid", 32'(rx_valid), 32'(exp_valid));
                chk("data", 32'(rx_data), 32'(exp_data));
                chk("frame_err", 32'(frame_err), 32'(exp_err));
                chk("overrun", 32'(overrun), 32'(exp_ovr));
                if (frame_err) err_cnt++;
                if (overrun) ovr_cnt++;
                if (rx_valid && !prev_v) vrise++;
            end
            prev_v = rx_valid;
            if (rnd_ready) rx_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic send_bit(input logic b);
        spi_mosi = b;
        tick(2);
        spi_clk = 1;
        tick(2);
        spi_clk = 0;
    endtask

    // rdy_end >= 0 forces rx_ready for the single clk in which the word completes
    task automatic frame(input logic [N-1:0] d, input int nb, input int rdy_end);
        spi_csn = 0;
        tick(2);
        for (int i = 0; i < nb; i++) send_bit(i < N ? d[N-1-i] : 1'($urandom));
        tick(2);
        spi_csn = 1;
        tick(2);
        if (rdy_end >= 0) rx_ready = rdy_end[0];
        tick(1);
        if (rdy_end >= 0) rx_ready = 0;
        tick(3);
    endtask

    task automatic consume();
        rx_ready = 1;
        tick(1);
        rx_ready = 0;
    endtask

    initial begin
        int e0, o0, v0, nb;
        int opts[7] = '{0, 3, 7, 8, 8, 8, 9};
        rst = 1; spi_csn = 1; spi_clk = 0; spi_mosi = 0; rx_ready = 0;
        tick(3);
        chk("rst_valid", 32'(rx_valid), 0);
        chk("rst_data", 32'(rx_data), 0);
        chk("rst_err", 32'(frame_err), 0);
        chk("rst_ovr", 32'(overrun), 0);
        rst = 0;
        tick(5);

        frame(8'hA5, 8, -1);
        chk("t1_valid", 32'(rx_valid), 1);
        chk("t1_data", 32'(rx_data), 32'h A5);
        consume();
        chk("t1_consumed", 32'(rx_valid), 0);
        chk("t1_hold", 32'(rx_data), 32'h A5);

        o0 = ovr_cnt; e0 = err_cnt;
        frame(8'h3C, 8, -1);
        frame(8'hC3, 8, -1);
        chk("t2_data", 32'(rx_data), 32'h 3C);
        chk("t2_ovr", 32'(ovr_cnt - o0), 1);
        chk("t2_err", 32'(err_cnt - e0), 0);
        consume();

        o0 = ovr_cnt;
        frame(8'h3C, 8, -1);
        frame(8'hC3, 8, 1);
        chk("t3_data", 32'(rx_data), 32'h C3);
        chk("t3_valid", 32'(rx_valid), 1);
        chk("t3_ovr", 32'(ovr_cnt - o0), 0);
        consume();

        e0 = err_cnt; v0 = vrise;
        frame(8'h5A, 5, -1);
        chk("t4_err5", 32'(err_cnt - e0), 1);
        frame(8'h5A, 9, -1);
        chk("t4_err9", 32'(err_cnt - e0), 2);
        chk("t4_novalid", 32'(vrise - v0), 0);

        e0 = err_cnt; v0 = vrise;
        spi_csn = 0;
        tick(10);
        spi_csn = 1;
        tick(6);
        chk("t5_err", 32'(err_cnt - e0), 0);
        chk("t5_novalid", 32'(vrise - v0), 0);

        e0 = err_cnt; v0 = vrise;
        spi_csn = 0;
        tick(2);
        for (int i = 0; i < 4; i++) send_bit(1);
        rst = 1;
        tick(1);
        chk("t6_rst_data", 32'(rx_data), 0);
        chk("t6_rst_valid", 32'(rx_valid), 0);
        rst = 0;
        for (int i = 0; i < 4; i++) send_bit(1);
        tick(2);
        spi_csn = 1;
        tick(6);
        chk("t6_err", 32'(err_cnt - e0), 0);
        chk("t6_novalid", 32'(vrise - v0), 0);
        frame(8'h81, 8, -1);
        chk("t6_data", 32'(rx_data), 32'h 81);
        chk("t6_valid", 32'(rx_valid), 1);
        consume();

        rnd_ready = 1;
        for (int k = 0; k < 40; k++) begin
            nb = opts[$urandom_range(0, 6)];
            frame(N'($urandom), nb, -1);
            tick($urandom_range(0, 3));
        end
        rnd_ready = 0;
        rx_ready = 0;
        tick(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/spi_receiver.md
Name: spi_receiver

Overview:
- Deserialises frames from the SPI transmitter back into parallel N-bit words in the system clock domain.
- Used as the on-chip loopback/checker stage directly downstream of the transmitter.
- Also used as the capture front end on the receiving FPGA.
- Oversamples spi_csn/spi_clk/spi_mosi with the system clock and presents each completed word on a valid/ready output with error flags.

Parameters:
- N, 8, word length in bits; must match the transmitter.
- SYNC_STAGES, 2, flip-flop depth of the input synchronisers (>= 2).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- spi_csn  input  1  frame select, active low.
- spi_clk  input  1  SPI clock, idle low; data sampled on its rising edge.
- spi_mosi  input  1  serial data, MSB first.
- rx_data  output  N  last accepted word.
- rx_valid  output  1  rx_data holds an unconsumed word.
- rx_ready  input  1  consumer accepts rx_data when rx_valid & rx_ready at a clk edge.
- frame_err  output  1  one-cycle pulse: frame ended with a bit count not 0 or N.
- overrun  output  1  one-cycle pulse: completed word dropped because output register was full.

Behaviour:
- Reset (async, rst=1):
  - rx_data=0, rx_valid=0, frame_err=0, overrun=0, bit counter=0, shift register=0, armed=0.
  - Synchroniser chains preset: csn=1, clk=0, mosi=0.
- Input timing:
  - Each of the three inputs passes through its own SYNC_STAGES-deep chain.
  - One further register on the synchronised csn and clk gives edge detection.
  - Input contract: every spi_clk and spi_csn level is stable for >= 2 clk periods. This is met by the 24 MHz/6 MHz defaults: a 2-clk half period.
- armed flag:
  - Set when synchronised csn is seen high.
  - Falling csn edges are honoured only while armed.
  - Consequence: a frame already in progress at reset release is ignored entirely, with no word and no error.
- csn falling edge (armed): clear bit counter and shift register; enter RECEIVE.
- RECEIVE, synchronised spi_clk rising edge:
  - Shift register <= {shift[N-2:0], mosi_sync}.
  - Counter increments, saturating at N+1.
  - Rising spi_clk edges while csn is high are ignored.
- csn rising edge (end of frame), by counter value:
  - Counter == N: word complete; go to deliver.
  - Counter == 0: empty frame; no action.
  - Any other value (1..N-1 or N+1): frame_err pulses for exactly one clk; shift register discarded; rx_data/rx_valid unchanged.
  - State returns to IDLE in all cases.
- Deliver:
  - If rx_valid=0, or rx_ready=1 in the same cycle: rx_data <= shift register, rx_valid <= 1, no overrun.
  - If rx_valid=1 and rx_ready=0: new word dropped, old rx_data kept, overrun pulses for one clk.
- Consume: rx_valid & rx_ready with no delivery that cycle -> rx_valid <= 0; rx_data holds its value.
- Latency:
  - rx_valid and frame_err assert on the (SYNC_STAGES+1)-th clk rising edge after spi_csn rises at the pin.
  - With defaults, that is the 3rd edge.
- States: IDLE (wait csn falling & armed), RECEIVE (count bits), then back to IDLE on csn rising.
- Simultaneous events:
  - csn rising and a spi_clk rising edge detected in the same clk: the bit is counted first, then end-of-frame is evaluated.
  - This is the contract-violation case; it is defined so the bench result is deterministic.
- Reset mid-frame: all state cleared as above; the partial word is lost; no frame_err is produced.

Test Plan:
- Send 0xA5 via transmitter (24/6 MHz), rx_ready=0 -> rx_valid rises 3 clk after spi_csn rises, rx_data=0xA5. Then rx_ready=1 for one cycle -> rx_valid=0 next edge.
- Send 0x3C then 0xC3 with rx_ready held 0 -> rx_data stays 0x3C, overrun pulses one cycle at the end of the second frame, frame_err stays 0.
- Same two frames with rx_ready=1 exactly in the cycle the second word completes -> rx_data=0xC3, rx_valid stays 1, no overrun.
- Hand-driven frame with 5 clocks, then a frame with 9 clocks -> frame_err pulses once per frame, rx_valid never asserts.
- Empty frame (csn low 10 clk, no spi_clk) -> no rx_valid, no frame_err.
- Assert rst after bit 4 of 0xFF and release with csn still low -> no word, no error for that frame. Next frame 0x81 is received correctly.
